// File: rtl/apb_master_if.sv
// Command/response port plus APB bus for the apb_master initiator.
// The master modport is the initiator's view; slave is the requester/target side.
interface apb_master_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic          cmd_write;
    logic [DW-1:0] cmd_wdata;
    logic [DW/8-1:0] cmd_strb;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;

    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW/8-1:0] pstrb;
    logic          pready;
    logic [DW-1:0] prdata;
    logic          pslverr;

    modport master (
        input  cmd_valid, cmd_addr, cmd_write, cmd_wdata, cmd_strb,
        input  rsp_ready, pready, prdata, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output psel, penable, pwrite, paddr, pwdata, pstrb
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_write, cmd_wdata, cmd_strb,
        output rsp_ready, pready, prdata, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  psel, penable, pwrite, paddr, pwdata, pstrb
    );
endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB3/APB4 initiator: valid/ready command in, APB SETUP/ACCESS
// transfer with wait-state timeout and alignment check, valid/ready response out.
module apb_master #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT     = 16,
    parameter int ALIGN_CHECK = 1
) (
    input  logic         clk,
    input  logic         rst,
    apb_master_if.master bus
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

    localparam int             CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit             TMO_EN   = (TIMEOUT > 0);
    localparam logic [CW-1:0]  TMO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic          misaligned;

    assign misaligned = (ALIGN_CHECK != 0) && (bus.cmd_addr[1:0] != 2'b00);

    // NOTE: cmd_ready decodes registered state and is gated by rst so it is
    // low for the whole reset, not just after the first clock edge.
    assign bus.cmd_ready = (state == S_IDLE) && !rst;

    // NOTE: all state and outputs use non-blocking assignments so every
    // branch sees pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            wait_cnt        <= '0;
            bus.psel        <= 1'b0;
            bus.penable     <= 1'b0;
            bus.pwrite      <= 1'b0;
            bus.paddr       <= '0;
            bus.pwdata      <= '0;
            bus.pstrb       <= '0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_rdata   <= '0;
            bus.rsp_err     <= 1'b0;
            bus.rsp_timeout <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        if (misaligned) begin
                            state           <= S_RESP;
                            bus.rsp_valid   <= 1'b1;
                            bus.rsp_rdata   <= '0;
                            bus.rsp_err     <= 1'b1;
                            bus.rsp_timeout <= 1'b0;
                        end else begin
                            state       <= S_SETUP;
                            bus.psel    <= 1'b1;
                            bus.penable <= 1'b0;
                            bus.paddr   <= bus.cmd_addr;
                            bus.pwrite  <= bus.cmd_write;
                            bus.pwdata  <= bus.cmd_wdata;
                            bus.pstrb   <= bus.cmd_write ? bus.cmd_strb : '0;
                        end
                    end
                end

                S_SETUP: begin
                    state       <= S_ACCESS;
                    bus.penable <= 1'b1;
                    wait_cnt    <= '0;
                end

                S_ACCESS: begin
                    // Completion wins over timeout when pready arrives on the last allowed cycle.
                    if (bus.pready) begin
                        state           <= S_RESP;
                        bus.psel        <= 1'b0;
                        bus.penable     <= 1'b0;
                        bus.rsp_valid   <= 1'b1;
                        bus.rsp_rdata   <= (bus.pwrite || bus.pslverr) ? '0 : bus.prdata;
                        bus.rsp_err     <= bus.pslverr;
                        bus.rsp_timeout <= 1'b0;
                    end else if (TMO_EN && (wait_cnt == TMO_LAST)) begin
                        state           <= S_RESP;
                        bus.psel        <= 1'b0;
                        bus.penable     <= 1'b0;
                        bus.rsp_valid   <= 1'b1;
                        bus.rsp_rdata   <= '0;
                        bus.rsp_err     <= 1'b1;
                        bus.rsp_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                S_RESP: begin
                    if (bus.rsp_ready) begin
                        state         <= S_IDLE;
                        bus.rsp_valid <= 1'b0;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: table of single transfers with a cycle-level
// APB target model, plus hand-written reset-related sequences.
module tb_apb_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] last_paddr = '0;

    apb_master_if #(.AW(AW), .DW(DW)) bus ();

    apb_master #(.AW(AW), .DW(DW), .TIMEOUT(TMO), .ALIGN_CHECK(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          waits;      // ACCESS cycles with pready low before pready high
        logic [31:0] prdata;
        logic        slverr;
        int          hold;       // cycles rsp_ready is held low once rsp_valid rises
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_to;
        int          exp_pen;    // expected penable cycles, 0 = no APB transfer
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_write = 1'b0;
        bus.cmd_wdata = '0;
        bus.cmd_strb  = '0;
        bus.rsp_ready = 1'b1;
        bus.pready    = 1'b0;
        bus.prdata    = 32'hBAD0BAD0;
        bus.pslverr   = 1'b0;
    endtask

    // Call at a negedge; returns at a negedge with the DUT back in IDLE.
    task automatic run_vec(input int id, input vec_t v);
        int          k;
        int          n;
        int          acc;
        int          psel_n;
        int          pen_n;
        int          unstable;
        bit          cap;
        logic [31:0] c_addr, c_wdata;
        logic [3:0]  c_strb;
        logic        c_write;
        int          exp_lat;
        string       tag;

        tag = $sformatf("v%0d", id);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = v.addr;
        bus.cmd_write = v.write;
        bus.cmd_wdata = v.wdata;
        bus.cmd_strb  = v.strb;
        bus.rsp_ready = (v.hold == 0);

        k = 0;
        while (!bus.cmd_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_accept_bound"}, 32'(k < 20), 32'd1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_wdata = 32'h5555AAAA;

        n = 0; acc = 0; psel_n = 0; pen_n = 0; unstable = 0; cap = 0;
        c_addr = '0; c_wdata = '0; c_strb = '0; c_write = 1'b0;
        while (!bus.rsp_valid && n < 60) begin
            if (bus.psel) begin
                psel_n++;
                if (!cap) begin
                    cap = 1; c_addr = bus.paddr; c_wdata = bus.pwdata;
                    c_strb = bus.pstrb; c_write = bus.pwrite;
                end else if (bus.paddr !== c_addr || bus.pwdata !== c_wdata ||
                             bus.pstrb !== c_strb || bus.pwrite !== c_write) begin
                    unstable++;
                end
            end
            if (bus.penable) begin
                pen_n++;
                acc++;
                bus.pready  = (acc > v.waits);
                bus.prdata  = bus.pready ? v.prdata : 32'hBAD0BAD0;
                bus.pslverr = bus.pready & v.slverr;
            end else begin
                bus.pready  = 1'b0;
                bus.pslverr = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
        bus.prdata  = 32'hBAD0BAD0;

        exp_lat = (v.exp_pen == 0) ? 0 : v.exp_pen + 1;
        check({tag, "_rsp_latency"}, 32'(n), 32'(exp_lat));
        check({tag, "_penable_cycles"}, 32'(pen_n), 32'(v.exp_pen));
        check({tag, "_psel_cycles"}, 32'(psel_n), 32'((v.exp_pen == 0) ? 0 : v.exp_pen + 1));
        if (v.exp_pen > 0) begin
            check({tag, "_paddr"}, c_addr, v.addr);
            check({tag, "_pwrite"}, 32'(c_write), 32'(v.write));
            check({tag, "_pstrb"}, 32'(c_strb), 32'(v.write ? v.strb : 4'h0));
            if (v.write) check({tag, "_pwdata"}, c_wdata, v.wdata);
            check({tag, "_stable"}, 32'(unstable), 32'd0);
            last_paddr = v.addr;
        end else begin
            check({tag, "_paddr_kept"}, bus.paddr, last_paddr);
        end
        check({tag, "_rsp_rdata"}, bus.rsp_rdata, v.exp_rdata);
        check({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'(v.exp_err));
        check({tag, "_rsp_timeout"}, 32'(bus.rsp_timeout), 32'(v.exp_to));

        for (int h = 0; h < v.hold; h++) begin
            check({tag, "_held_valid"}, 32'(bus.rsp_valid), 32'd1);
            check({tag, "_held_cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
            check({tag, "_held_err"}, 32'(bus.rsp_err), 32'(v.exp_err));
            @(negedge clk);
        end
        if (v.hold > 0) begin
            check({tag, "_valid_at_handshake"}, 32'(bus.rsp_valid), 32'd1);
            check({tag, "_cmd_ready_at_handshake"}, 32'(bus.cmd_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check({tag, "_rsp_valid_drop"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, "_cmd_ready_back"}, 32'(bus.cmd_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t wv;

        //          wr    addr          wdata         strb  wt   prdata        err  hold  exp_rdata     eerr  eto  pen
        vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0,   32'h0,        1'b0, 0, 32'h0,        1'b0, 1'b0, 1};
        vecs[1] = '{1'b0, 32'h0000_0004, 32'h0,         4'hF, 3,   32'h1234_5678, 1'b0, 0, 32'h1234_5678, 1'b0, 1'b0, 4};
        vecs[2] = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 0,   32'h0,        1'b1, 5, 32'h0,        1'b1, 1'b0, 1};
        vecs[3] = '{1'b1, 32'h0000_0024, 32'h0BAD_F00D, 4'h3, 1,   32'h0,        1'b0, 0, 32'h0,        1'b0, 1'b0, 2};
        vecs[4] = '{1'b0, 32'h0000_0040, 32'h0,         4'h0, 200, 32'h0,        1'b0, 0, 32'h0,        1'b1, 1'b1, 16};
        vecs[5] = '{1'b0, 32'h0000_0044, 32'h0,         4'h0, 15,  32'hCAFE_F00D, 1'b0, 0, 32'hCAFE_F00D, 1'b0, 1'b0, 16};
        vecs[6] = '{1'b1, 32'h0000_0013, 32'h1111_2222, 4'hF, 0,   32'h0,        1'b0, 0, 32'h0,        1'b1, 1'b0, 0};
        vecs[7] = '{1'b0, 32'h0000_0012, 32'h0,         4'h0, 0,   32'h7777_7777, 1'b0, 0, 32'h0,        1'b1, 1'b0, 0};
        vecs[8] = '{1'b1, 32'h0000_0008, 32'h9999_0000, 4'hC, 2,   32'h0,        1'b1, 0, 32'h0,        1'b1, 1'b0, 3};
        vecs[9] = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 0,   32'hFFFF_FFFF, 1'b0, 0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1};

        drive_idle();
        #1;
        check("reset_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("reset_psel", 32'(bus.psel), 32'd0);
        check("reset_penable", 32'(bus.penable), 32'd0);
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_paddr", bus.paddr, 32'd0);
        check("reset_pstrb", 32'(bus.pstrb), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // Asynchronous reset in the middle of ACCESS with a stuck target.
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 32'h0000_0030;
        bus.cmd_write = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_penable_before", 32'(bus.penable), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_psel", 32'(bus.psel), 32'd0);
        check("rst_mid_penable", 32'(bus.penable), 32'd0);
        check("rst_mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_mid_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_release_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        @(negedge clk);
        last_paddr = '0;
        wv = '{1'b1, 32'h0000_0050, 32'hA5A5_5A5A, 4'h5, 1, 32'h0, 1'b0, 0, 32'h0, 1'b0, 1'b0, 2};
        run_vec(10, wv);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
